cs_host_controller: RTL and testbench

Host-side initiator for the computational storage array. It accepts queued operation requests (read, write, add, subtract) on a valid/ready interface and issues each one as a single-cycle command on the storage bus (cmd, addA/addB/addC, shared tri-state DQ). It captures read data from DQ and returns one in-order completion per request on a valid/ready response interface. It sits between the system datapath and the storage array and is the only driver of the array's command inputs and of the host side of DQ.

---
 rtl/cs_host_controller.sv | 199 +++++++++++++++++++
 tb/tb_cs_host_controller.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cs_host_controller.sv
// cs_host_controller: host-side initiator for the computational storage array.
// Queues read/write/add/sub requests, issues each one as a single-cycle
// storage-bus command and returns one in-order completion per request.
module cs_host_controller #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_a,
  input  logic [ADDR_W-1:0] req_b,
  input  logic [ADDR_W-1:0] req_c,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_op,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        cmd,
  output logic [ADDR_W-1:0] addA,
  output logic [ADDR_W-1:0] addB,
  output logic [ADDR_W-1:0] addC,
  inout  wire  [DATA_W-1:0] DQ,
  output logic              busy,
  output logic [15:0]       ops_done
);

  localparam int         PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [1:0] OP_RD = 2'b00;
  localparam logic [1:0] OP_WR = 2'b01;

  typedef struct packed {
    logic [1:0]        op;
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] b;
    logic [ADDR_W-1:0] c;
    logic [DATA_W-1:0] wdata;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_RESP  = 2'b10
  } state_t;

  // Request queue: pointers carry one extra wrap bit to tell full from empty.
  entry_t             fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]     wr_ptr;
  logic [PTR_W:0]     rd_ptr;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  entry_t             head;

  // FSM and stage controls.
  state_t             state;
  state_t             state_nxt;
  logic               load_bus;
  logic               capture;
  logic               vld_p1;
  logic               hshake;

  // Bus stage (_p0): what the array sees during ISSUE.
  logic [1:0]         cmd_p0;
  logic [ADDR_W-1:0]  addA_p0;
  logic [ADDR_W-1:0]  addB_p0;
  logic [ADDR_W-1:0]  addC_p0;
  logic [DATA_W-1:0]  dq_out_p0;
  logic               dq_en_p0;

  // Response stage (_p1): completion presented to the consumer.
  logic [1:0]         rsp_op_p1;
  logic [DATA_W-1:0]  rsp_data_p1;
  logic [15:0]        ops_cnt;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign req_ready = !full;
  assign push      = req_valid && !full;
  assign head      = fifo_mem[rd_ptr[PTR_W-1:0]];
  assign hshake    = vld_p1 && rsp_ready;

  // Queue storage: data only, no reset needed since pointers gate validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[PTR_W-1:0]] <= '{op: req_op, a: req_a, b: req_b,
                                       c: req_c, wdata: req_wdata};
    end
  end

  // Queue pointers: push and pop in the same cycle are both honoured.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + {{PTR_W{1'b0}}, 1'b1};
      if (pop)  rd_ptr <= rd_ptr + {{PTR_W{1'b0}}, 1'b1};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM next state and stage strobes; one op outstanding at a time.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load_bus  = 1'b0;
    capture   = 1'b0;
    vld_p1    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          load_bus  = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        capture   = 1'b1;
        state_nxt = S_RESP;
      end
      S_RESP: begin
        vld_p1 = 1'b1;
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---- stage p0: storage bus command registers ----
  // Load the head entry for one cycle, then fall back to the idle read of
  // address 0; the bus has no NOP so the idle state must be a harmless read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_p0    <= OP_RD;
      addA_p0   <= '0;
      addB_p0   <= '0;
      addC_p0   <= '0;
      dq_out_p0 <= '0;
      dq_en_p0  <= 1'b0;
    end else if (load_bus) begin
      cmd_p0    <= head.op;
      addA_p0   <= head.a;
      addB_p0   <= head.b;
      addC_p0   <= head.c;
      dq_out_p0 <= head.wdata;
      dq_en_p0  <= (head.op == OP_WR);
    end else if (capture) begin
      cmd_p0    <= OP_RD;
      addA_p0   <= '0;
      addB_p0   <= '0;
      addC_p0   <= '0;
      dq_out_p0 <= '0;
      dq_en_p0  <= 1'b0;
    end
  end

  // DQ enable comes from the same register as cmd, so it is only on with WR.
  assign DQ   = dq_en_p0 ? dq_out_p0 : {DATA_W{1'bz}};
  assign cmd  = cmd_p0;
  assign addA = addA_p0;
  assign addB = addB_p0;
  assign addC = addC_p0;

  // ---- stage p1: completion capture ----
  // Sample DQ at the closing edge of ISSUE; only reads return data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_op_p1   <= OP_RD;
      rsp_data_p1 <= '0;
    end else if (capture) begin
      rsp_op_p1   <= cmd_p0;
      rsp_data_p1 <= (cmd_p0 == OP_RD) ? DQ : '0;
    end
  end

  // Completion counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      ops_cnt <= '0;
    else if (hshake) ops_cnt <= ops_cnt + 16'd1;
  end

  assign rsp_valid = vld_p1;
  assign rsp_op    = rsp_op_p1;
  assign rsp_data  = rsp_data_p1;
  assign ops_done  = ops_cnt;
  assign busy      = !empty || (state != S_IDLE);

endmodule

// File: tb/tb_cs_host_controller.sv
// Testbench for cs_host_controller: storage array model on the bus, an
// in-order reference scoreboard, table vectors, corner sequences and random.
module tb_cs_host_controller;

  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam logic [1:0] RD  = 2'b00;
  localparam logic [1:0] WR  = 2'b01;
  localparam logic [1:0] ADD = 2'b10;
  localparam logic [1:0] SUB = 2'b11;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_a, req_b, req_c;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_op;
  logic [DATA_W-1:0] rsp_data;
  logic [1:0]        cmd;
  logic [ADDR_W-1:0] addA, addB, addC;
  wire  [DATA_W-1:0] dq;
  logic              busy;
  logic [15:0]       ops_done;

  always #5 clk = ~clk;

  cs_host_controller #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
    .rsp_data(rsp_data), .cmd(cmd), .addA(addA), .addB(addB), .addC(addC),
    .DQ(dq), .busy(busy), .ops_done(ops_done)
  );

  // Storage array: drives DQ with mem[addA] on reads, commits at the edge.
  logic [DATA_W-1:0] arr [256];
  logic              arr_clr;
  assign dq = (cmd == RD) ? arr[addA] : {DATA_W{1'bz}};

  always @(posedge clk) begin
    if (arr_clr) begin
      for (int i = 0; i < 256; i++) arr[i] <= '0;
    end else begin
      case (cmd)
        WR:      arr[addC] <= dq;
        ADD:     arr[addC] <= arr[addA] + arr[addB];
        SUB:     arr[addC] <= arr[addA] - arr[addB];
        default: ;
      endcase
    end
  end

  // Reference model: memory updated in request order, expected completions.
  typedef struct packed { logic [1:0] op; logic [DATA_W-1:0] data; } rsp_t;
  rsp_t              exp_q[$];
  logic [DATA_W-1:0] ref_mem [256];
  logic [15:0]       exp_cnt;
  int                tests, fails;
  logic              prev_cmd_nz;
  logic              stall_hold;
  logic [1:0]        held_op;
  logic [DATA_W-1:0] held_data;
  int                wr_cycles;

  typedef struct {
    string             name;
    logic [1:0]        op;
    logic [ADDR_W-1:0] a, b, c;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        eop;
    logic [DATA_W-1:0] edata;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic model_push(input logic [1:0] op, input logic [ADDR_W-1:0] a,
                            input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] c,
                            input logic [DATA_W-1:0] wd);
    rsp_t r;
    r.op   = op;
    r.data = '0;
    case (op)
      RD:  r.data = ref_mem[a];
      WR:  ref_mem[c] = wd;
      ADD: ref_mem[c] = ref_mem[a] + ref_mem[b];
      SUB: ref_mem[c] = ref_mem[a] - ref_mem[b];
      default: ;
    endcase
    exp_q.push_back(r);
  endtask

  // One clock: account for the coming edge, then check outputs at negedge.
  task automatic cycle();
    rsp_t e;
    if (req_valid && req_ready) model_push(req_op, req_a, req_b, req_c, req_wdata);
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL rsp_unexpected: actual completion op %0d, required none", rsp_op);
      end else begin
        e = exp_q.pop_front();
        check("rsp_op", 32'(rsp_op), 32'(e.op));
        check("rsp_data", 32'(rsp_data), 32'(e.data));
      end
      exp_cnt    = exp_cnt + 16'd1;
      stall_hold = 1'b0;
    end else if (rsp_valid) begin
      if (stall_hold) begin
        check("stall_rsp_op", 32'(rsp_op), 32'(held_op));
        check("stall_rsp_data", 32'(rsp_data), 32'(held_data));
      end
      stall_hold = 1'b1;
      held_op    = rsp_op;
      held_data  = rsp_data;
    end else begin
      stall_hold = 1'b0;
    end
    @(negedge clk);
    check("ops_done", 32'(ops_done), 32'(exp_cnt));
    if (cmd != RD) check("cmd_one_cycle", 32'(prev_cmd_nz), 32'd0);
    prev_cmd_nz = (cmd != RD);
    if (cmd == WR) wr_cycles++;
    if (rsp_valid || !busy) begin
      check("idle_bus_cmd", 32'(cmd), 32'(RD));
      check("idle_bus_addr", 32'({addA, addB, addC}), 32'd0);
    end
    if (cmd == RD) check("dq_released", 32'(dq), 32'(arr[addA]));
  endtask

  task automatic wait_rsp(input string name, input int limit);
    int n;
    n = 0;
    while (!rsp_valid && n < limit) begin
      cycle();
      n++;
    end
    check(name, 32'(rsp_valid), 32'd1);
  endtask

  task automatic drain(input string name);
    int n;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 300) begin
      cycle();
      n++;
    end
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic set_req(input logic [1:0] op, input logic [ADDR_W-1:0] a,
                         input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] c,
                         input logic [DATA_W-1:0] wd);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_c     = c;
    req_wdata = wd;
  endtask

  initial begin
    int   accepted;
    int   idx[$];
    logic acc;
    logic [15:0] cnt_before;

    tests = 0; fails = 0; exp_cnt = '0;
    prev_cmd_nz = 1'b0; stall_hold = 1'b0; held_op = '0; held_data = '0;
    wr_cycles = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;

    vecs[0] = '{"wr_beef",  WR,  8'h00, 8'h00, 8'h05, 16'hBEEF, WR,  16'h0000};
    vecs[1] = '{"rd_beef",  RD,  8'h05, 8'h00, 8'h00, 16'h0000, RD,  16'hBEEF};
    vecs[2] = '{"wr_1",     WR,  8'h00, 8'h00, 8'h01, 16'h0003, WR,  16'h0000};
    vecs[3] = '{"wr_2",     WR,  8'h00, 8'h00, 8'h02, 16'h0005, WR,  16'h0000};
    vecs[4] = '{"sub",      SUB, 8'h01, 8'h02, 8'h03, 16'h1234, SUB, 16'h0000};
    vecs[5] = '{"rd_wrap",  RD,  8'h03, 8'h00, 8'h00, 16'h0000, RD,  16'hFFFE};
    vecs[6] = '{"add",      ADD, 8'h01, 8'h02, 8'h03, 16'h0000, ADD, 16'h0000};
    vecs[7] = '{"rd_sum",   RD,  8'h03, 8'h00, 8'h00, 16'h0000, RD,  16'h0008};

    // Power-on reset and reset values.
    reset = 1'b0; arr_clr = 1'b1;
    req_valid = 1'b0; req_op = RD; req_a = '0; req_b = '0; req_c = '0; req_wdata = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_op", 32'(rsp_op), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_cmd", 32'(cmd), 32'd0);
    check("rst_addr", 32'({addA, addB, addC}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ops_done", 32'(ops_done), 32'd0);
    arr_clr = 1'b0;
    reset   = 1'b1;
    cycle();

    // Table vectors, one request at a time, with latency checks.
    rsp_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      set_req(vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].wdata);
      wr_cycles = 0;
      cycle();
      req_valid = 1'b0;
      check({vecs[v].name, "_lat_n1_valid"}, 32'(rsp_valid), 32'd0);
      cycle();
      check({vecs[v].name, "_bus_cmd"}, 32'(cmd), 32'(vecs[v].op));
      check({vecs[v].name, "_bus_addr"}, 32'({addA, addB, addC}),
            32'({vecs[v].a, vecs[v].b, vecs[v].c}));
      cycle();
      check({vecs[v].name, "_lat_rsp_valid"}, 32'(rsp_valid), 32'd1);
      if (!rsp_valid) wait_rsp({vecs[v].name, "_timeout"}, 10);
      check({vecs[v].name, "_op"}, 32'(rsp_op), 32'(vecs[v].eop));
      check({vecs[v].name, "_data"}, 32'(rsp_data), 32'(vecs[v].edata));
      cycle();
      if (vecs[v].op == WR) check({vecs[v].name, "_wr_cycles"}, 32'(wr_cycles), 32'd1);
    end

    // Throughput: three queued ops with rsp_ready high complete 3 cycles apart.
    for (int i = 0; i < 20; i++) begin
      if (i < 3) set_req(WR, 8'h00, 8'h00, 8'(8'h20 + i), 16'(16'h5000 + i));
      else       req_valid = 1'b0;
      cycle();
      if (rsp_valid) idx.push_back(i);
    end
    check("thr_count", 32'(idx.size()), 32'd3);
    if (idx.size() == 3) begin
      check("thr_gap1", 32'(idx[1] - idx[0]), 32'd3);
      check("thr_gap2", 32'(idx[2] - idx[1]), 32'd3);
    end
    drain("thr_drain");

    // Backpressure: one in flight plus FIFO_DEPTH queued, then req_ready drops.
    cnt_before = exp_cnt;
    rsp_ready  = 1'b0;
    accepted   = 0;
    for (int i = 0; i < 12; i++) begin
      case (accepted)
        0: set_req(WR,  8'h00, 8'h00, 8'h30, 16'hA000);
        1: set_req(WR,  8'h00, 8'h00, 8'h31, 16'hA001);
        2: set_req(ADD, 8'h30, 8'h31, 8'h32, 16'h0000);
        3: set_req(RD,  8'h32, 8'h00, 8'h00, 16'h0000);
        4: set_req(SUB, 8'h30, 8'h31, 8'h33, 16'h0000);
        default: set_req(RD, 8'h33, 8'h00, 8'h00, 16'h0000);
      endcase
      acc = req_ready;
      cycle();
      if (acc) accepted++;
    end
    check("bp_accepted", 32'(accepted), 32'(FIFO_DEPTH + 1));
    check("bp_req_ready", 32'(req_ready), 32'd0);
    check("bp_busy", 32'(busy), 32'd1);
    drain("bp_drain");
    check("bp_ops_done", 32'(ops_done), 32'(16'(cnt_before + 16'(accepted))));

    // Counter wrap from 0xFFFF.
    force dut.ops_cnt = 16'hFFFF;
    #1;
    release dut.ops_cnt;
    exp_cnt = 16'hFFFF;
    cycle();
    check("wrap_preload", 32'(ops_done), 32'hFFFF);
    set_req(RD, 8'h05, 8'h00, 8'h00, 16'h0000);
    cycle();
    req_valid = 1'b0;
    wait_rsp("wrap_rsp_timeout", 10);
    cycle();
    check("wrap_ops_done", 32'(ops_done), 32'h0000);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom_range(0, 1) == 1);
      req_op    = 2'($urandom_range(0, 3));
      req_a     = 8'($urandom_range(0, 15));
      req_b     = 8'($urandom_range(0, 15));
      req_c     = 8'($urandom_range(0, 15));
      req_wdata = 16'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain("rand_drain");

    // Asynchronous reset during ISSUE of a write, with another request queued.
    rsp_ready = 1'b1;
    set_req(WR, 8'h00, 8'h00, 8'hC8, 16'hBEEF);
    cycle();
    set_req(WR, 8'h00, 8'h00, 8'hC9, 16'h1111);
    cycle();
    req_valid = 1'b0;
    check("rst_mid_pre_cmd", 32'(cmd), 32'(WR));
    reset = 1'b0;
    #1;
    check("rst_mid_cmd", 32'(cmd), 32'd0);
    check("rst_mid_addr", 32'({addA, addB, addC}), 32'd0);
    check("rst_mid_dq", 32'(dq), 32'(arr[0]));
    check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_mid_ops_done", 32'(ops_done), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    exp_q.delete();
    exp_cnt = '0; prev_cmd_nz = 1'b0; stall_hold = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) cycle();
    check("rst_post_busy", 32'(busy), 32'd0);
    check("rst_post_req_ready", 32'(req_ready), 32'd1);
    check("rst_post_rsp_valid", 32'(rsp_valid), 32'd0);
    set_req(RD, 8'h01, 8'h00, 8'h00, 16'h0000);
    cycle();
    req_valid = 1'b0;
    wait_rsp("rst_post_rsp_timeout", 10);
    drain("rst_post_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
